lc3_mem_access: RTL and testbench
=================================

# lc3_mem_access

Memory-access unit for the LC-3 datapath, sitting between the instruction-cycle controller and the unified instruction/data memory. It watches the controller's 4-bit `state`, launches fetch, indirect-address read, data read and data write transactions, waits on the memory's variable-latency ready handshake, and latches the results into IR, MDR and an indirect-address register. It returns the one-cycle `complete` pulse that the controller's states 1, 6, 7 and 8 wait on.

## Interface
- `TIMEOUT`, default 255: `mem_ready` wait cycles before the transaction aborts with `mem_err`.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `state` input 4: controller state. 1 is fetch, 6 is indirect read, 7 is read, 8 is write, 0 is update PC. Other values are ignored.
- `pc` input 16: current PC, the address used for fetch.
- `ea` input 16: effective address computed in state 5.
- `store_data` input 16: register-file data for writes.
- `mem_dout` input 16: memory read data.
- `mem_ready` input 1: memory has finished the current request.
- `mem_addr` output 16: memory address.
- `mem_din` output 16: memory write data.
- `mem_rd` output 1: read request.
- `mem_wr` output 1: write request.
- `complete` output 1: one-cycle done pulse to the controller.
- `ir` output 16: instruction register.
- `mdr` output 16: memory data register.
- `mem_err` output 1: sticky timeout flag.

## Operation
- FSM states are IDLE, REQ and DONE.
- **IDLE:** if `state` is 1, 6, 7 or 8, select the address and direction, register them onto `mem_addr` / `mem_din` / `mem_rd` / `mem_wr`, and go to REQ. Otherwise hold all request outputs at 0.
- **Address selection:**
  - state 1 uses `pc`.
  - state 6 uses `ea`.
  - states 7 and 8 use `ind_addr` when `ind_valid` is 1, otherwise `ea`.
- **Direction:** state 8 is a write, with `mem_din` = `store_data` sampled at launch. All other launching states are reads.
- **REQ:** hold the request outputs stable until `mem_ready` is sampled high. Then:
  - state 1 loads `ir` ← `mem_dout`.
  - state 6 loads `ind_addr` ← `mem_dout` and sets `ind_valid` ← 1.
  - state 7 loads `mdr` ← `mem_dout`.
  - state 8 loads nothing.
  - Drop `mem_rd` / `mem_wr`, raise `complete`, go to DONE.
- **DONE:** `complete` = 1 for exactly this cycle, then unconditionally return to IDLE. The controller leaves its memory state on this same edge, so no request is relaunched.
- **Indirect flag:** `ind_valid` clears whenever `state` = 0 or state 1 launches. A new instruction therefore never reuses a stale indirect pointer.
- **Timeout:** a wait counter runs in REQ.
  - If it reaches `TIMEOUT` without `mem_ready`, set `mem_err`, drop the requests and return to IDLE without pulsing `complete`.
  - `mem_err` clears only on reset.
- A change of `state` while in REQ or DONE is ignored. The transaction in flight finishes.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, `ind_addr` = 0, `ind_valid` = 0, wait counter 0.
- **Reset mid-transaction:** `mem_rd` / `mem_wr` / `complete` drop immediately (asynchronously). No register is updated.
- **Latency:** memory state visible in cycle n; request outputs valid from cycle n+1.
  - With `mem_ready` high in cycle n+k (k ≥ 1), `complete` is high in cycle n+k+1 and the result register updates at the end of cycle n+k.
  - Minimum latency from state entry to `complete` is 2 cycles.
- **Data availability:** `ir` / `mdr` are valid in the same cycle `complete` is high, so decode in state 2 sees the new `ir`.
- **Back-to-back memory states** (6→7, 6→8): each is a separate transaction. IDLE lasts one cycle between them.
- `mem_ready` is ignored outside REQ.

## Structure
- Shared package `lc3_pkg` holds:
  - controller state encodings (`S_UPDATE_PC`=0 … `S_UPDATE_RF`=9, `S_INVALID`=15), so both blocks decode the same constants;
  - the access FSM enum `{IDLE, REQ, DONE}`;
  - a 16-bit word typedef.
- One natural sub-module: `lc3_mem_timeout`, the wait counter with `start` / `clear` inputs and an `expired` output. Everything else stays flat.

## Test plan
- **Fetch:** reset, then `state`=1, `pc`=0x3000, memory ready after 3 cycles returning 0x1261 → `mem_rd`=1 with `mem_addr`=0x3000 for 3 cycles; `ir`=0x1261; single `complete` pulse 4 cycles after state entry.
- **Indirect load:**
  - `state` 6 with `ea`=0x4000 returns 0x5000 → `ind_valid`=1.
  - Then `state` 7 → read at 0x5000, `mdr`=data.
  - Then `state` 0 → `ind_valid`=0.
- **Store:** `state`=8, `ea`=0x4100, `store_data`=0xBEEF, `ind_valid`=0 → `mem_wr`=1, `mem_addr`=0x4100, `mem_din`=0xBEEF, `mdr` unchanged, one `complete`.
- **Zero-wait ready** (`mem_ready` tied high) across 6→8 → two separate `complete` pulses, each 2 cycles after its state entry, with one IDLE cycle between.
- **Timeout:** `TIMEOUT`=4, `mem_ready` held low in `state` 1 → `mem_err`=1 after 4 wait cycles, requests drop, no `complete`.
- **Reset mid-REQ:** assert `reset` while `mem_rd`=1 → `mem_rd`, `complete` and `ir` at 0 immediately. After release with `state`=1, a fresh fetch launches.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: controller state codes, access FSM encoding, word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3_pkg;

    typedef logic [15:0] word_t;
    typedef logic [3:0]  ctrl_state_t;

    localparam ctrl_state_t S_UPDATE_PC = 4'd0;
    localparam ctrl_state_t S_FETCH     = 4'd1;
    localparam ctrl_state_t S_DECODE    = 4'd2;
    localparam ctrl_state_t S_ALU       = 4'd3;
    localparam ctrl_state_t S_BRANCH    = 4'd4;
    localparam ctrl_state_t S_CALC_ADDR = 4'd5;
    localparam ctrl_state_t S_IND_READ  = 4'd6;
    localparam ctrl_state_t S_MEM_READ  = 4'd7;
    localparam ctrl_state_t S_MEM_WRITE = 4'd8;
    localparam ctrl_state_t S_UPDATE_RF = 4'd9;
    localparam ctrl_state_t S_INVALID   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_IND_READ) ||
               (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/lc3_mem_timeout.sv
// Wait counter for a memory request; expired fires on the TIMEOUT-th unanswered cycle.
// Latency: combinational expired from the registered count.
// Backpressure: none; counts while start is high, zeroed by clear.
module lc3_mem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = start && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access unit: fetch / indirect / read / write with a ready handshake.
// Latency: requests out one cycle after state entry; complete one cycle after mem_ready.
// Backpressure: holds the request until mem_ready, aborts with sticky mem_err on timeout.
module lc3_mem_access
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [15:0] pc,
    input  logic [15:0] ea,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        complete,
    output logic [15:0] ir,
    output logic [15:0] mdr,
    output logic        mem_err
);

    acc_state_t  fsm, fsm_nxt;
    ctrl_state_t op_q;
    word_t       addr_q, din_q, ind_addr, launch_addr;
    logic        ind_valid;
    logic        launch, waiting, expired;

    assign launch  = (fsm == IDLE) && is_mem_state(state);
    assign waiting = (fsm == REQ) && !mem_ready;

    always_comb begin
        launch_addr = ea;
        if (state == S_FETCH) begin
            launch_addr = pc;
        end else if ((state == S_MEM_READ || state == S_MEM_WRITE) && ind_valid) begin
            launch_addr = ind_addr;
        end
    end

    lc3_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .start   (waiting),
        .clear   (fsm != REQ),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (launch) fsm_nxt = REQ;
            REQ: begin
                if (mem_ready) begin
                    fsm_nxt = DONE;
                end else if (expired) begin
                    fsm_nxt = IDLE;
                end
            end
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Request outputs are only live in REQ so that IDLE/DONE and reset show a quiet bus.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        complete = 1'b0;
        case (fsm)
            REQ: begin
                mem_addr = addr_q;
                mem_rd   = (op_q != S_MEM_WRITE);
                mem_wr   = (op_q == S_MEM_WRITE);
                if (op_q == S_MEM_WRITE) mem_din = din_q;
            end
            DONE:    complete = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= S_UPDATE_PC;
            addr_q    <= '0;
            din_q     <= '0;
            ir        <= '0;
            mdr       <= '0;
            ind_addr  <= '0;
            ind_valid <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            if (launch) begin
                op_q   <= state;
                addr_q <= launch_addr;
                din_q  <= store_data;
            end
            if (fsm == REQ && mem_ready) begin
                case (op_q)
                    S_FETCH:    ir <= mem_dout;
                    S_IND_READ: begin
                        ind_addr  <= mem_dout;
                        ind_valid <= 1'b1;
                    end
                    S_MEM_READ: mdr <= mem_dout;
                    default: ;
                endcase
            end
            if (expired) mem_err <= 1'b1;
            // A new instruction must never reuse the previous instruction's pointer.
            if (state == S_UPDATE_PC || (launch && state == S_FETCH)) begin
                ind_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed plus randomized bench for lc3_mem_access against a transaction-level model.
module tb_lc3_mem_access;
    import lc3_pkg::*;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  state = 4'd0;
    logic [15:0] pc = '0, ea = '0, store_data = '0, mem_dout = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr, mem_din, ir, mdr;
    logic        mem_rd, mem_wr, complete, mem_err;

    lc3_mem_access #(.TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .pc         (pc),
        .ea         (ea),
        .store_data (store_data),
        .mem_dout   (mem_dout),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .complete   (complete),
        .ir         (ir),
        .mdr        (mdr),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    word_t mem_m [word_t];
    word_t m_ir = '0, m_mdr = '0, m_ind_addr = '0;
    logic  m_ind_valid = 1'b0, m_err = 1'b0;

    function automatic word_t mem_read(input word_t a);
        return mem_m.exists(a) ? mem_m[a] : ((a ^ 16'h5A3C) + 16'h0101);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rd, input logic wr, input logic cpl);
        chk({tag, ".rd"},  {15'd0, mem_rd},   {15'd0, rd});
        chk({tag, ".wr"},  {15'd0, mem_wr},   {15'd0, wr});
        chk({tag, ".cpl"}, {15'd0, complete}, {15'd0, cpl});
        chk({tag, ".ir"},  ir,  m_ir);
        chk({tag, ".mdr"}, mdr, m_mdr);
        chk({tag, ".err"}, {15'd0, mem_err},  {15'd0, m_err});
    endtask

    task automatic chk_quiet(input string tag);
        chk_ctl(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, ".addr"}, mem_addr, 16'h0000);
        chk({tag, ".din"},  mem_din,  16'h0000);
    endtask

    task automatic model_reset();
        m_ir = '0; m_mdr = '0; m_ind_addr = '0; m_ind_valid = 1'b0; m_err = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge closing the access.
    // lat = cycle (1..TO) of REQ in which memory answers; 0 means it never answers.
    task automatic access(input ctrl_state_t st, input int lat);
        word_t a, sd, d;
        logic  wr_op;
        int    lim;
        state = st;
        wr_op = (st == S_MEM_WRITE);
        sd    = store_data;
        if (st == S_FETCH) m_ind_valid = 1'b0;
        if (st == S_FETCH)         a = pc;
        else if (st == S_IND_READ) a = ea;
        else                       a = m_ind_valid ? m_ind_addr : ea;
        d = mem_read(a);
        mem_dout  = d;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk_quiet("idle");
        lim = (lat == 0) ? TO : lat;
        for (int j = 1; j <= lim; j++) begin
            @(posedge clock); #1;
            mem_ready  = (j == lat);
            state      = 4'($urandom_range(1, 15));
            pc         = 16'($urandom);
            ea         = 16'($urandom);
            store_data = 16'($urandom);
            @(negedge clock);
            chk_ctl("req", !wr_op, wr_op, 1'b0);
            chk("req.addr", mem_addr, a);
            if (wr_op) chk("req.din", mem_din, sd);
        end
        @(posedge clock); #1;
        mem_ready = 1'b0;
        if (lat == 0) begin
            m_err = 1'b1;
            state = S_DECODE;
            @(negedge clock);
            chk_quiet("tmo");
        end else begin
            case (st)
                S_FETCH:     m_ir = d;
                S_IND_READ:  begin m_ind_addr = d; m_ind_valid = 1'b1; end
                S_MEM_READ:  m_mdr = d;
                default:     mem_m[a] = sd;
            endcase
            mem_ready = 1'($urandom_range(0, 1));
            mem_dout  = 16'($urandom);
            state     = 4'($urandom_range(1, 15));
            @(negedge clock);
            chk_ctl("done", 1'b0, 1'b0, 1'b1);
        end
        @(posedge clock); #1;
        mem_ready = 1'b0;
        state     = S_DECODE;
    endtask

    task automatic pc_update();
        state = S_UPDATE_PC;
        @(negedge clock);
        chk_quiet("upd");
        @(posedge clock); #1;
        m_ind_valid = 1'b0;
        state = S_DECODE;
    endtask

    initial begin
        // Reset state
        #3;
        chk_quiet("rst_async");
        @(negedge clock);
        chk_quiet("rst");
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // Fetch with three-cycle memory
        pc = 16'h3000;
        mem_m[16'h3000] = 16'h1261;
        access(S_FETCH, 3);
        chk("fetch.ir", ir, 16'h1261);

        // Indirect load, then pointer dropped by PC update
        ea = 16'h4000;
        mem_m[16'h4000] = 16'h5000;
        mem_m[16'h5000] = 16'hABCD;
        access(S_IND_READ, 2);
        ea = 16'h4010;
        access(S_MEM_READ, 1);
        chk("ind.mdr", mdr, 16'hABCD);
        pc_update();
        ea = 16'h4200;
        access(S_MEM_READ, 1);

        // Store without pointer
        ea = 16'h4100;
        store_data = 16'hBEEF;
        access(S_MEM_WRITE, 2);
        chk("store.mdr", mdr, m_mdr);
        ea = 16'h4100;
        access(S_MEM_READ, 4);
        chk("store.readback", mdr, 16'hBEEF);

        // Zero-wait back-to-back 6 -> 8
        pc_update();
        ea = 16'h4001;
        access(S_IND_READ, 1);
        store_data = 16'h1357;
        access(S_MEM_WRITE, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 4);
            pc         = 16'($urandom);
            ea         = 16'h4000 + 16'($urandom_range(0, 3));
            store_data = 16'($urandom);
            case (r)
                0:       pc_update();
                1:       access(S_FETCH,     $urandom_range(1, TO));
                2:       access(S_IND_READ,  $urandom_range(1, TO));
                3:       access(S_MEM_READ,  $urandom_range(1, TO));
                default: access(S_MEM_WRITE, $urandom_range(1, TO));
            endcase
        end

        // Timeout, then sticky error across a normal access
        pc = 16'h3010;
        access(S_FETCH, 0);
        ea = 16'h4002;
        access(S_MEM_READ, 2);

        // Reset in the middle of a request
        pc = 16'h3020;
        state = S_FETCH;
        mem_ready = 1'b0;
        mem_dout = 16'hFFFF;
        @(posedge clock); #1;
        state = S_DECODE;
        @(negedge clock);
        chk("mid.rd", {15'd0, mem_rd}, 16'h0001);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_quiet("arst");
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;
        pc = 16'h3000;
        access(S_FETCH, 1);
        chk("refetch.ir", ir, 16'h1261);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
